complex_mac_pipe: RTL and testbench
===================================

Name: complex_mac_pipe

Overview:
- Pipelined, parametrised complex multiply / multiply-accumulate unit. It is the clocked successor to the combinational complex arithmetic blocks.
- Inputs and outputs are signed fixed point, W bits with FRAC fractional bits.
- Operation is selectable per beat: multiply, conjugate-multiply, accumulate, or restart-accumulate.
- Results are rounded and saturated, with valid/ready handshakes on both sides. The block feeds FFT butterflies and correlators.

Parameters:
W, 32, width of each real/imag part (signed, two's complement)
FRAC, 16, fractional bits of the input/output format (0 <= FRAC < W)
G, 8, accumulator guard bits above full product width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input this cycle
op  in  2  00 MUL a*b; 01 CMUL a*conj(b); 10 MAC acc+=a*b; 11 MACSTART acc=a*b
a_re, a_im  in  W each  operand a
b_re, b_im  in  W each  operand b
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
c_re, c_im  out  W each  rounded, saturated result
ovf  out  1  sticky saturation flag
clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Reset (asynchronous, active-high):
  - Clears all pipeline valid bits, the accumulator, c_re, c_im, out_valid and ovf to 0.
  - in_ready is 1 while rst is high.
  - Beats in flight when reset asserts are discarded.
- Pipeline: 3 stages, fixed latency of 3 cycles from accepted input to out_valid with no stall.
  - S1 registers the four 2W-bit products ar*br, ai*bi, ar*bi, ai*br, plus op.
  - S2 combines the products at full precision, width 2W+1:
    - MUL: re = ar*br - ai*bi; im = ar*bi + ai*br.
    - CMUL: re = ar*br + ai*bi; im = ai*br - ar*bi.
  - S2 accumulator update (width 2W+1+G, per re/im part):
    - MAC: acc <= acc + p.
    - MACSTART: acc <= p.
    - S2 output value is acc_next for MAC/MACSTART and p for MUL/CMUL.
    - MUL and CMUL leave acc unchanged.
  - S3 rounds: adds 2^(FRAC-1) (nothing if FRAC=0), then arithmetic right-shifts by FRAC. This is round-half-up toward +inf.
  - S3 saturates each part to [-2^(W-1), 2^(W-1)-1] and registers the result onto c_re and c_im.
- Accumulator overflow: the accumulator wraps modulo 2^(2W+1+G) and does not saturate. Only the output saturates.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0 the whole pipeline holds, including the accumulator.
  - An input is accepted on in_valid && in_ready. A result is consumed on out_valid && out_ready.
  - c_re, c_im and out_valid hold stable while out_valid=1 and out_ready=0.
  - Bubbles (in_valid=0) propagate as invalid stages. The accumulator changes only when a valid MAC or MACSTART beat advances through S2.
- Back-to-back MAC beats accumulate with no gap; throughput is 1 beat/cycle with out_ready held at 1.
- ovf:
  - Set in the cycle a saturated result is registered into S3. Setting takes priority over a same-cycle clr_ovf.
  - Otherwise cleared by clr_ovf.
  - Never cleared by normal traffic.
- op is sampled only with an accepted beat. The value of op when in_valid=0 is ignored.

Test Plan:
- MUL, no stall, defaults: a=(0x00010000, 0x00020000) (1+j2), b=(0x00030000, 0xFFFF0000) (3-j1) -> exactly 3 cycles later out_valid=1, c=(0x00050000, 0x00050000), ovf=0.
- CMUL with the same operands -> c=(0x00010000, 0x00070000) (1+j7).
- Rounding:
  - a=(0x00000001, 0), b=(0x00008000, 0) -> c_re=0x00000001.
  - a=(0xFFFFFFFF, 0), same b -> c_re=0x00000000 (half rounds up).
- MAC sequence:
  - MACSTART (1+j0)*(2+j0), then MAC (1+j1)*(1+j1) on consecutive cycles -> outputs (2, 0) then (2, 2), in Q16.16 as 0x00020000 and 0x00020000.
  - A following MUL does not disturb acc, and a next MAC adds onto (2, 2).
- Saturation: a=b=(0x7FFF0000, 0) MUL -> c_re=0x7FFFFFFF, ovf=1 and ovf stays 1.
  - Negative case, a=(0x80000000, 0), b=(0x7FFF0000, 0) -> c_re=0x80000000.
  - clr_ovf pulse -> ovf=0.
- Backpressure and reset:
  - Hold out_ready=0 with 4 beats offered -> exactly 3 accepted, in_ready=0, outputs stable. Releasing out_ready drains them in order, then a 4th beat is accepted.
  - Asserting rst mid-stream -> out_valid, acc and ovf go to 0 immediately. The first MAC after reset equals a*b.

Source files
------------

// File: rtl/complex_mac_pipe.sv
// Pipelined complex multiply / multiply-accumulate with rounding and saturation.
// Three stages (products, combine/accumulate, round/saturate) with a global stall on backpressure.
module complex_mac_pipe #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int G    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_re,
    input  logic [W-1:0] a_im,
    input  logic [W-1:0] b_re,
    input  logic [W-1:0] b_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c_re,
    output logic [W-1:0] c_im,
    output logic         ovf,
    input  logic         clr_ovf
);

    localparam int PW = 2 * W;
    localparam int AW = PW + 1 + G;
    localparam logic [1:0] OP_MUL      = 2'b00;
    localparam logic [1:0] OP_CMUL     = 2'b01;
    localparam logic [1:0] OP_MAC      = 2'b10;
    localparam logic [1:0] OP_MACSTART = 2'b11;
    localparam logic [AW:0] RND = (FRAC == 0) ? '0
                                : ((AW+1)'(1) << ((FRAC == 0) ? 0 : FRAC - 1));

    function automatic logic signed [PW-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
        smul = PW'($signed(x)) * PW'($signed(y));
    endfunction

    // Returns {saturated, value}: round half up, shift out FRAC bits, clamp to W bits.
    function automatic logic [W:0] round_sat(input logic [AW-1:0] v);
        logic signed [AW:0] s;
        s = $signed({v[AW-1], v}) + $signed(RND);
        s = s >>> FRAC;
        if ((&s[AW:W-1]) || !(|s[AW:W-1]))
            round_sat = {1'b0, s[W-1:0]};
        else if (s[AW])
            round_sat = {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            round_sat = {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    logic                 advance;
    logic                 v1, v2;
    logic [1:0]           op1;
    logic signed [PW-1:0] prr, pii, pri, pir;
    logic signed [AW-1:0] acc_re, acc_im, s2_re, s2_im;
    logic signed [PW:0]   rr, ii, ri, ir, p_re, p_im;
    logic signed [AW-1:0] pe_re, pe_im, an_re, an_im;
    logic [W:0]           rs_re, rs_im;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            op1 <= OP_MUL;
            prr <= '0;
            pii <= '0;
            pri <= '0;
            pir <= '0;
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                op1 <= op;
                prr <= smul(a_re, b_re);
                pii <= smul(a_im, b_im);
                pri <= smul(a_re, b_im);
                pir <= smul(a_im, b_re);
            end
        end
    end

    always_comb begin
        rr = {prr[PW-1], prr};
        ii = {pii[PW-1], pii};
        ri = {pri[PW-1], pri};
        ir = {pir[PW-1], pir};
        if (op1 == OP_CMUL) begin
            p_re = rr + ii;
            p_im = ir - ri;
        end else begin
            p_re = rr - ii;
            p_im = ri + ir;
        end
        pe_re = {{G{p_re[PW]}}, p_re};
        pe_im = {{G{p_im[PW]}}, p_im};
        an_re = (op1 == OP_MAC) ? acc_re + pe_re : pe_re;
        an_im = (op1 == OP_MAC) ? acc_im + pe_im : pe_im;
    end

    // The accumulator wraps; only the rounded output is clamped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            s2_re  <= '0;
            s2_im  <= '0;
            acc_re <= '0;
            acc_im <= '0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                s2_re <= op1[1] ? an_re : pe_re;
                s2_im <= op1[1] ? an_im : pe_im;
            end
            if (v1 && (op1 == OP_MAC || op1 == OP_MACSTART)) begin
                acc_re <= an_re;
                acc_im <= an_im;
            end
        end
    end

    assign rs_re = round_sat(s2_re);
    assign rs_im = round_sat(s2_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            c_re      <= '0;
            c_im      <= '0;
            ovf       <= 1'b0;
        end else begin
            if (advance) begin
                out_valid <= v2;
                if (v2) begin
                    c_re <= rs_re[W-1:0];
                    c_im <= rs_im[W-1:0];
                end
            end
            if (advance && v2 && (rs_re[W] || rs_im[W]))
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complex_mac_pipe.sv
// Bench for complex_mac_pipe: directed cases plus randomized traffic against a complex-arithmetic model.
module tb_complex_mac_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] c_re, c_im;
    logic        ovf;
    logic        clr_ovf = 1'b0;

    complex_mac_pipe #(.W(32), .FRAC(16), .G(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready), .c_re(c_re), .c_im(c_im),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: exact complex arithmetic on wide integers.
    typedef struct { logic [31:0] re; logic [31:0] im; bit sat; } exp_t;
    exp_t q[$];
    logic signed [127:0] m_acc_re = '0, m_acc_im = '0;
    bit m_ovf = 0;

    function automatic logic signed [127:0] wrap_acc(input logic signed [127:0] v);
        logic signed [127:0] t;
        t = v <<< (128 - 73);
        return t >>> (128 - 73);
    endfunction

    function automatic void to_out(input logic signed [127:0] v, output logic [31:0] r, output bit s);
        logic signed [127:0] t, hi, lo;
        hi = 128'sd2147483647;
        lo = -128'sd2147483648;
        t = (v + 128'sd32768) >>> 16;
        s = 1'b1;
        if (t > hi) r = 32'h7FFFFFFF;
        else if (t < lo) r = 32'h80000000;
        else begin r = t[31:0]; s = 1'b0; end
    endfunction

    function automatic void model_push(input logic [1:0] o, input logic [31:0] ar, ai, br, bi);
        logic signed [127:0] xr, xi, yr, yi, pr, pi, vr, vi;
        exp_t e;
        bit sr, si;
        xr = 128'($signed(ar)); xi = 128'($signed(ai));
        yr = 128'($signed(br)); yi = 128'($signed(bi));
        if (o == 2'b01) begin
            pr = xr * yr + xi * yi;
            pi = xi * yr - xr * yi;
        end else begin
            pr = xr * yr - xi * yi;
            pi = xr * yi + xi * yr;
        end
        vr = pr; vi = pi;
        if (o == 2'b10) begin
            m_acc_re = wrap_acc(m_acc_re + pr);
            m_acc_im = wrap_acc(m_acc_im + pi);
            vr = m_acc_re; vi = m_acc_im;
        end else if (o == 2'b11) begin
            m_acc_re = pr; m_acc_im = pi;
        end
        to_out(vr, e.re, sr);
        to_out(vi, e.im, si);
        e.sat = sr | si;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_out", 64'(q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    m_ovf = m_ovf | e.sat;
                    check_eq("c_re", c_re, e.re);
                    check_eq("c_im", c_im, e.im);
                    check_eq("ovf", ovf, m_ovf);
                end
            end
            if (in_valid && in_ready) model_push(op, a_re, a_im, b_re, b_im);
            if (clr_ovf) m_ovf = 0;
        end
    end

    task automatic drive(input logic [1:0] o, input logic [31:0] ar, ai, br, bi);
        in_valid = 1'b1; op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
    endtask

    task automatic send(input logic [1:0] o, input logic [31:0] ar, ai, br, bi);
        bit ok;
        ok = 0;
        drive(o, ar, ai, br, bi);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("out_seen", out_valid, 1'b1);
    endtask

    int lat, idx;
    logic [31:0] held_re;

    initial begin
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_c", {c_re, c_im}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // (1+j2)*(3-j1) = 5+j5
        send(2'b00, 32'h00010000, 32'h00020000, 32'h00030000, 32'hFFFF0000);
        wait_out(lat);
        check_eq("mul_latency", 64'(lat), 64'd3);
        check_eq("mul_c", {c_re, c_im}, {32'h00050000, 32'h00050000});
        check_eq("mul_ovf", ovf, 1'b0);

        send(2'b01, 32'h00010000, 32'h00020000, 32'h00030000, 32'hFFFF0000);
        wait_out(lat);
        check_eq("cmul_c", {c_re, c_im}, {32'h00010000, 32'h00070000});

        send(2'b00, 32'h00000001, 32'h0, 32'h00008000, 32'h0);
        wait_out(lat);
        check_eq("round_pos", c_re, 32'h00000001);
        send(2'b00, 32'hFFFFFFFF, 32'h0, 32'h00008000, 32'h0);
        wait_out(lat);
        check_eq("round_half_up", c_re, 32'h00000000);

        send(2'b11, 32'h00010000, 32'h0, 32'h00020000, 32'h0);
        send(2'b10, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
        wait_out(lat);
        check_eq("macstart_c", {c_re, c_im}, {32'h00020000, 32'h00000000});
        @(posedge clk); #1;
        check_eq("mac_c", {c_re, c_im}, {32'h00020000, 32'h00020000});
        send(2'b00, 32'h00010000, 32'h0, 32'h00050000, 32'h0);
        wait_out(lat);
        check_eq("mul_between", {c_re, c_im}, {32'h00050000, 32'h00000000});
        send(2'b10, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        wait_out(lat);
        check_eq("mac_resume", {c_re, c_im}, {32'h00030000, 32'h00020000});

        send(2'b00, 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0);
        wait_out(lat);
        check_eq("sat_pos", c_re, 32'h7FFFFFFF);
        check_eq("sat_ovf", ovf, 1'b1);
        send(2'b00, 32'h80000000, 32'h0, 32'h7FFF0000, 32'h0);
        wait_out(lat);
        check_eq("sat_neg", c_re, 32'h80000000);
        send(2'b00, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        wait_out(lat);
        check_eq("ovf_sticky", ovf, 1'b1);
        repeat (2) @(posedge clk);
        #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        check_eq("ovf_cleared", ovf, 1'b0);

        // Backpressure: four beats offered, only the three pipeline slots fill.
        out_ready = 1'b0;
        idx = 0;
        held_re = '0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive(2'b00, (idx + 1) << 16, 32'h0, 32'h00010000, 32'h0);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid && cyc == 4) held_re = c_re;
            @(posedge clk); #1;
        end
        check_eq("bp_accepted", 64'(idx), 64'd3);
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_held_first", held_re, 32'h00010000);
        check_eq("bp_stable", {out_valid, c_re}, {1'b1, 32'h00010000});
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && idx < 4; cyc++) begin
            drive(2'b00, (idx + 1) << 16, 32'h0, 32'h00010000, 32'h0);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("bp_fourth", 64'(idx), 64'd4);
        repeat (6) @(posedge clk);
        #1;

        // Reset mid-stream with a live accumulator and ovf set.
        send(2'b11, 32'h00030000, 32'h0, 32'h00010000, 32'h0);
        send(2'b00, 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0);
        send(2'b10, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        send(2'b10, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
        check_eq("pre_rst_ovf", ovf, 1'b1);
        rst = 1'b1;
        q.delete();
        m_acc_re = '0; m_acc_im = '0; m_ovf = 0;
        #1;
        check_eq("rst_mid_valid", out_valid, 1'b0);
        check_eq("rst_mid_ovf", ovf, 1'b0);
        check_eq("rst_mid_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(2'b10, 32'h00010000, 32'h00010000, 32'h00020000, 32'h0);
        wait_out(lat);
        check_eq("mac_after_rst", {c_re, c_im}, {32'h00020000, 32'h00020000});
        @(posedge clk); #1;

        // Randomized traffic with random bubbles and backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a_re = $urandom; a_im = $urandom; b_re = $urandom; b_im = $urandom;
            end else begin
                a_re = $urandom_range(0, 32'h80000) - 32'h40000;
                a_im = $urandom_range(0, 32'h80000) - 32'h40000;
                b_re = $urandom_range(0, 32'h80000) - 32'h40000;
                b_im = $urandom_range(0, 32'h80000) - 32'h40000;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
